// File: rtl/tx_rx_pkg.sv
// Shared types and constants for the tx_rx serial loopback block:
// the frame FSM states, the latched frame configuration and the
// active-low 7-segment glyph table.
package tx_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Bit order matches SWIn[9:8] so the switches can be latched directly.
  typedef struct packed {
    logic par_odd;
    logic par_en;
  } frame_cfg_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_E = 7'b0000110;

  // Segments {g,f,e,d,c,b,a}, active-low; entry 0 is the rightmost.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // Even parity is the plain XOR of the data; odd parity inverts it.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Nibble to active-low 7-segment glyph, looked up in the shared table.
module hex_to_7seg
  import tx_rx_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/tx_rx.sv
// Serial loopback: a UART-style transmitter sends the switch byte on an
// internal line, a receiver on the same clock recovers it, and four
// 7-segment digits show the sent and received bytes.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | TX: line high, waiting for a Start edge; RX: waiting for line=0
// START  | start bit (line 0); RX aborts if the mid-bit sample is high
// DATA   | 8 data bits, LSB first
// PARITY | optional parity bit, only when the latched config enables it
// STOP   | stop bit (line 1); RX commits or flags an error at its sample
module tx_rx
  import tx_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [9:0] SWIn,
  output logic [6:0] Hex1,
  output logic [6:0] Hex2,
  output logic [6:0] Hex3,
  output logic [6:0] Hex4
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit ONE_CLK = (CLKS_PER_BIT == 1);

  logic          start_q;
  logic          start_qq;
  logic          start_edge;

  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_byte;
  frame_cfg_t    cfg;
  logic          line;

  state_t        rx_state;
  logic [CW-1:0] rx_pos;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          rx_err;
  logic          rx_par_ok;

  logic [6:0]    seg_rx_lo;
  logic [6:0]    seg_rx_hi;

  // Register Start once more so a level held high yields a single edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      start_q  <= 1'b0;
      start_qq <= 1'b0;
    end else begin
      start_q  <= Start;
      start_qq <= start_q;
    end
  end

  assign start_edge = start_q & ~start_qq;

  // Transmitter: bit timing from a down-counter, line driven as a register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_byte  <= '0;
      cfg      <= '0;
      line     <= 1'b1;
    end else begin
      case (tx_state)
        IDLE: begin
          line <= 1'b1;
          if (start_edge) begin
            tx_byte  <= SWIn[7:0];
            cfg      <= SWIn[9:8];
            tx_state <= START;
            tx_cnt   <= BIT_LAST;
            line     <= 1'b0;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            tx_state <= DATA;
            tx_cnt   <= BIT_LAST;
            tx_bit   <= '0;
            line     <= tx_byte[0];
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 3'd7) begin
              if (cfg.par_en) begin
                tx_state <= PARITY;
                line     <= parity_bit(tx_byte, cfg.par_odd);
              end else begin
                tx_state <= STOP;
                line     <= 1'b1;
              end
            end else begin
              tx_bit <= tx_bit + 3'd1;
              line   <= tx_byte[tx_bit + 3'd1];
            end
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        PARITY: begin
          if (tx_cnt == '0) begin
            tx_state <= STOP;
            tx_cnt   <= BIT_LAST;
            line     <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        STOP: begin
          line <= 1'b1;
          if (tx_cnt == '0) begin
            tx_state <= IDLE;
          end else begin
            tx_cnt <= tx_cnt - CNT_ONE;
          end
        end
        default: begin
          tx_state <= IDLE;
          line     <= 1'b1;
        end
      endcase
    end
  end

  // Receiver: the cycle that first sees line=0 counts as position 0 of the
  // start bit, so RX bit windows line up exactly with TX and every bit is
  // sampled at position BIT_MID, including the CLKS_PER_BIT=1 case.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_state  <= IDLE;
      rx_pos    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_err    <= 1'b0;
      rx_par_ok <= 1'b1;
    end else begin
      case (rx_state)
        IDLE: begin
          if (!line) begin
            rx_bit    <= '0;
            rx_par_ok <= 1'b1;
            if (ONE_CLK) begin
              rx_state <= DATA;
              rx_pos   <= '0;
            end else begin
              rx_state <= START;
              rx_pos   <= CNT_ONE;
            end
          end
        end
        START: begin
          if (rx_pos == BIT_MID && line) begin
            rx_state <= IDLE;
            rx_pos   <= '0;
          end else if (rx_pos == BIT_LAST) begin
            rx_state <= DATA;
            rx_pos   <= '0;
          end else begin
            rx_pos <= rx_pos + CNT_ONE;
          end
        end
        DATA: begin
          if (rx_pos == BIT_MID) begin
            rx_shift <= {line, rx_shift[7:1]};
          end
          if (rx_pos == BIT_LAST) begin
            rx_pos <= '0;
            if (rx_bit == 3'd7) begin
              rx_state <= cfg.par_en ? PARITY : STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_pos <= rx_pos + CNT_ONE;
          end
        end
        PARITY: begin
          if (rx_pos == BIT_MID) begin
            rx_par_ok <= (line == parity_bit(rx_shift, cfg.par_odd));
          end
          if (rx_pos == BIT_LAST) begin
            rx_state <= STOP;
            rx_pos   <= '0;
          end else begin
            rx_pos <= rx_pos + CNT_ONE;
          end
        end
        STOP: begin
          // Return to IDLE right at the sample so a back-to-back frame is seen.
          if (rx_pos == BIT_MID) begin
            rx_state <= IDLE;
            rx_pos   <= '0;
            if (line && (rx_par_ok || !cfg.par_en)) begin
              rx_byte <= rx_shift;
              rx_err  <= 1'b0;
            end else begin
              rx_err <= 1'b1;
            end
          end else begin
            rx_pos <= rx_pos + CNT_ONE;
          end
        end
        default: begin
          rx_state <= IDLE;
          rx_pos   <= '0;
        end
      endcase
    end
  end

  hex_to_7seg u_hex1 (.digit(tx_byte[3:0]), .seg(Hex1));
  hex_to_7seg u_hex2 (.digit(tx_byte[7:4]), .seg(Hex2));
  hex_to_7seg u_hex3 (.digit(rx_byte[3:0]), .seg(seg_rx_lo));
  hex_to_7seg u_hex4 (.digit(rx_byte[7:4]), .seg(seg_rx_hi));

  assign Hex3 = rx_err ? SEG_E : seg_rx_lo;
  assign Hex4 = rx_err ? SEG_E : seg_rx_hi;

endmodule

// File: tb/tb_tx_rx.sv
// Directed bench for tx_rx with CLKS_PER_BIT=2; each task drives one
// scenario and compares outputs against hand-computed glyphs and line bits.
module tb_tx_rx;
  import tx_rx_pkg::*;

  localparam logic [6:0] H_0 = 7'b1000000;
  localparam logic [6:0] H_3 = 7'b0110000;
  localparam logic [6:0] H_5 = 7'b0010010;
  localparam logic [6:0] H_8 = 7'b0000000;
  localparam logic [6:0] H_A = 7'b0001000;
  localparam logic [6:0] H_C = 7'b1000110;
  localparam logic [6:0] H_E = 7'b0000110;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic [9:0] SWIn;
  logic [6:0] Hex1, Hex2, Hex3, Hex4;

  int n_tests = 0;
  int n_fail  = 0;

  tx_rx #(.CLKS_PER_BIT(2)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .Start(Start),
    .SWIn (SWIn),
    .Hex1 (Hex1),
    .Hex2 (Hex2),
    .Hex3 (Hex3),
    .Hex4 (Hex4)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // One frame with a Start pulse of 'hold' cycles, 37 cycles in total.
  // bits[k] is the line during the first cycle of frame bit k.
  task automatic run_frame(input logic [9:0] sw, input int hold, input int chg_at,
                           input logic [9:0] sw_chg, output logic [10:0] bits,
                           output int lows_after);
    bits = '0;
    lows_after = 0;
    SWIn = sw;
    Start = 1'b1;
    tick(2);
    for (int i = 0; i < 35; i++) begin
      if (i < 22 && (i % 2) == 0) bits[i/2] = dut.line;
      if (i >= 22 && dut.line === 1'b0) lows_after++;
      if (i == chg_at) SWIn = sw_chg;
      if (i + 2 == hold) Start = 1'b0;
      tick(1);
    end
    Start = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1; Start = 1'b0; SWIn = '0;
    tick(3);
    n_tests++; if (dut.line !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b want 1", dut.line); end
    n_tests++; if (Hex1 !== H_0) begin n_fail++; $display("FAIL reset_hex1: got %b want %b", Hex1, H_0); end
    n_tests++; if (Hex2 !== H_0) begin n_fail++; $display("FAIL reset_hex2: got %b want %b", Hex2, H_0); end
    n_tests++; if (Hex3 !== H_0) begin n_fail++; $display("FAIL reset_hex3: got %b want %b", Hex3, H_0); end
    n_tests++; if (Hex4 !== H_0) begin n_fail++; $display("FAIL reset_hex4: got %b want %b", Hex4, H_0); end
    RST = 1'b0;
    tick(3);
    n_tests++; if (dut.line !== 1'b1) begin n_fail++; $display("FAIL idle_line: got %b want 1", dut.line); end
    n_tests++; if (Hex3 !== H_0) begin n_fail++; $display("FAIL idle_hex3: got %b want %b", Hex3, H_0); end
  endtask

  task automatic test_single_frame;
    logic [9:0] exp_line;
    exp_line = 10'b1100010100;  // start, 8A LSB first, stop
    SWIn = 10'h08A;
    Start = 1'b1;
    tick(2);
    n_tests++; if (Hex2 !== H_8) begin n_fail++; $display("FAIL single_hex2: got %b want %b", Hex2, H_8); end
    n_tests++; if (Hex1 !== H_A) begin n_fail++; $display("FAIL single_hex1: got %b want %b", Hex1, H_A); end
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (dut.line !== exp_line[i/2]) begin
        n_fail++;
        $display("FAIL single_line[%0d]: got %b want %b", i, dut.line, exp_line[i/2]);
      end
      if (i == 2) Start = 1'b0;
      tick(1);
    end
    tick(2);
    n_tests++; if (Hex4 !== H_8) begin n_fail++; $display("FAIL single_hex4: got %b want %b", Hex4, H_8); end
    n_tests++; if (Hex3 !== H_A) begin n_fail++; $display("FAIL single_hex3: got %b want %b", Hex3, H_A); end
    tick(4);
  endtask

  task automatic test_sequence;
    logic [9:0]  sw_tab [3];
    logic [6:0]  hi_tab [3];
    logic [10:0] bits;
    int          lows;
    sw_tab = '{10'h0AA, 10'h0CA, 10'h0EA};
    hi_tab = '{H_A, H_C, H_E};
    for (int k = 0; k < 3; k++) begin
      run_frame(sw_tab[k], 2, -1, 10'h000, bits, lows);
      n_tests++; if (Hex4 !== hi_tab[k]) begin n_fail++; $display("FAIL seq%0d_hex4: got %b want %b", k, Hex4, hi_tab[k]); end
      n_tests++; if (Hex3 !== H_A) begin n_fail++; $display("FAIL seq%0d_hex3: got %b want %b", k, Hex3, H_A); end
      n_tests++; if (dut.rx_err !== 1'b0) begin n_fail++; $display("FAIL seq%0d_err: got %b want 0", k, dut.rx_err); end
    end
  endtask

  task automatic test_parity;
    logic [10:0] bits;
    int          lows;
    run_frame(10'h1AA, 2, -1, 10'h000, bits, lows);
    n_tests++; if (bits[8:1] !== 8'hAA) begin n_fail++; $display("FAIL even_data: got %h want aa", bits[8:1]); end
    n_tests++; if (bits[9] !== 1'b0) begin n_fail++; $display("FAIL even_parity_bit: got %b want 0", bits[9]); end
    n_tests++; if (bits[10] !== 1'b1) begin n_fail++; $display("FAIL even_stop_bit: got %b want 1", bits[10]); end
    n_tests++; if (Hex4 !== H_A || Hex3 !== H_A) begin n_fail++; $display("FAIL even_rx: got %b/%b want %b/%b", Hex4, Hex3, H_A, H_A); end
    n_tests++; if (dut.rx_err !== 1'b0) begin n_fail++; $display("FAIL even_err: got %b want 0", dut.rx_err); end
    run_frame(10'h3AA, 2, -1, 10'h000, bits, lows);
    n_tests++; if (bits[9] !== 1'b1) begin n_fail++; $display("FAIL odd_parity_bit: got %b want 1", bits[9]); end
    n_tests++; if (bits[10] !== 1'b1) begin n_fail++; $display("FAIL odd_stop_bit: got %b want 1", bits[10]); end
    n_tests++; if (Hex4 !== H_A || Hex3 !== H_A) begin n_fail++; $display("FAIL odd_rx: got %b/%b want %b/%b", Hex4, Hex3, H_A, H_A); end
    n_tests++; if (dut.rx_err !== 1'b0) begin n_fail++; $display("FAIL odd_err: got %b want 0", dut.rx_err); end
  endtask

  task automatic test_stop_error;
    logic [10:0] bits;
    int          lows;
    int          budget;
    SWIn = 10'h05A;
    Start = 1'b1;
    tick(2);
    Start = 1'b0;
    budget = 0;
    while (dut.tx_state != STOP && budget < 40) begin
      tick(1);
      budget++;
    end
    n_tests++; if (dut.tx_state !== STOP) begin n_fail++; $display("FAIL stop_wait: timed out, state %0d want %0d", dut.tx_state, STOP); end
    force dut.line = 1'b0;
    tick(1);
    force dut.line = 1'b1;
    tick(1);
    release dut.line;
    tick(4);
    n_tests++; if (Hex3 !== H_E) begin n_fail++; $display("FAIL err_hex3: got %b want %b", Hex3, H_E); end
    n_tests++; if (Hex4 !== H_E) begin n_fail++; $display("FAIL err_hex4: got %b want %b", Hex4, H_E); end
    n_tests++; if (dut.rx_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", dut.rx_err); end
    n_tests++; if (Hex2 !== H_5 || Hex1 !== H_A) begin n_fail++; $display("FAIL err_tx: got %b/%b want %b/%b", Hex2, Hex1, H_5, H_A); end
    tick(20);
    run_frame(10'h0C3, 2, -1, 10'h000, bits, lows);
    n_tests++; if (Hex4 !== H_C) begin n_fail++; $display("FAIL recover_hex4: got %b want %b", Hex4, H_C); end
    n_tests++; if (Hex3 !== H_3) begin n_fail++; $display("FAIL recover_hex3: got %b want %b", Hex3, H_3); end
    n_tests++; if (dut.rx_err !== 1'b0) begin n_fail++; $display("FAIL recover_err: got %b want 0", dut.rx_err); end
  endtask

  task automatic test_hold_and_change;
    logic [10:0] bits;
    int          lows;
    run_frame(10'h055, 30, 6, 10'h0FF, bits, lows);
    n_tests++; if (lows !== 0) begin n_fail++; $display("FAIL hold_extra_frame: got %0d low cycles want 0", lows); end
    n_tests++; if (bits[8:1] !== 8'h55) begin n_fail++; $display("FAIL change_line_data: got %h want 55", bits[8:1]); end
    n_tests++; if (Hex4 !== H_5 || Hex3 !== H_5) begin n_fail++; $display("FAIL change_rx: got %b/%b want %b/%b", Hex4, Hex3, H_5, H_5); end
    n_tests++; if (Hex2 !== H_5 || Hex1 !== H_5) begin n_fail++; $display("FAIL change_tx: got %b/%b want %b/%b", Hex2, Hex1, H_5, H_5); end
  endtask

  task automatic test_busy_ignored;
    SWIn = 10'h0AA;
    Start = 1'b1;
    tick(2);
    Start = 1'b0;
    tick(8);
    SWIn = 10'h0FF;
    Start = 1'b1;
    tick(2);
    Start = 1'b0;
    tick(30);
    n_tests++; if (Hex2 !== H_A || Hex1 !== H_A) begin n_fail++; $display("FAIL busy_tx: got %b/%b want %b/%b", Hex2, Hex1, H_A, H_A); end
    n_tests++; if (Hex4 !== H_A || Hex3 !== H_A) begin n_fail++; $display("FAIL busy_rx: got %b/%b want %b/%b", Hex4, Hex3, H_A, H_A); end
    n_tests++; if (dut.line !== 1'b1) begin n_fail++; $display("FAIL busy_line: got %b want 1", dut.line); end
  endtask

  task automatic test_back_to_back;
    SWIn = 10'h03C;
    Start = 1'b1;
    tick(2);
    Start = 1'b0;
    tick(19);
    n_tests++; if (Hex4 !== H_3 || Hex3 !== H_C) begin n_fail++; $display("FAIL b2b_first_rx: got %b/%b want %b/%b", Hex4, Hex3, H_3, H_C); end
    n_tests++; if (dut.line !== 1'b1) begin n_fail++; $display("FAIL b2b_stop_line: got %b want 1", dut.line); end
    SWIn = 10'h0A5;
    Start = 1'b1;
    tick(1);
    n_tests++; if (Hex2 !== H_3 || Hex1 !== H_C) begin n_fail++; $display("FAIL b2b_pre_latch: got %b/%b want %b/%b", Hex2, Hex1, H_3, H_C); end
    tick(1);
    n_tests++; if (Hex2 !== H_A || Hex1 !== H_5) begin n_fail++; $display("FAIL b2b_latch: got %b/%b want %b/%b", Hex2, Hex1, H_A, H_5); end
    n_tests++; if (dut.line !== 1'b0) begin n_fail++; $display("FAIL b2b_start_bit: got %b want 0", dut.line); end
    Start = 1'b0;
    tick(22);
    n_tests++; if (Hex4 !== H_A || Hex3 !== H_5) begin n_fail++; $display("FAIL b2b_second_rx: got %b/%b want %b/%b", Hex4, Hex3, H_A, H_5); end
    n_tests++; if (dut.rx_err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", dut.rx_err); end
  endtask

  task automatic test_reset_mid;
    SWIn = 10'h0F0;
    Start = 1'b1;
    tick(2);
    Start = 1'b0;
    tick(8);
    RST = 1'b1;
    tick(1);
    n_tests++; if (dut.line !== 1'b1) begin n_fail++; $display("FAIL rstmid_line: got %b want 1", dut.line); end
    n_tests++; if (Hex1 !== H_0 || Hex2 !== H_0) begin n_fail++; $display("FAIL rstmid_tx: got %b/%b want %b/%b", Hex2, Hex1, H_0, H_0); end
    n_tests++; if (Hex3 !== H_0 || Hex4 !== H_0) begin n_fail++; $display("FAIL rstmid_rx: got %b/%b want %b/%b", Hex4, Hex3, H_0, H_0); end
    RST = 1'b0;
    tick(30);
    n_tests++; if (Hex3 !== H_0 || Hex4 !== H_0) begin n_fail++; $display("FAIL rstmid_partial: got %b/%b want %b/%b", Hex4, Hex3, H_0, H_0); end
    n_tests++; if (dut.line !== 1'b1) begin n_fail++; $display("FAIL rstmid_after_line: got %b want 1", dut.line); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_sequence;
    test_parity;
    test_stop_error;
    test_hold_and_change;
    test_busy_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
